// File: rtl/dcmi_pkg.sv
// Shared constants for the DCMI clock-domain-crossing blocks.
package dcmi_pkg;
  localparam int unsigned DCMI_DW = 8;
endpackage

// File: rtl/dcmi_sync2.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset to 0.
module dcmi_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/dcmi_hsync.sv
// Toggle-handshake word transfer from sclk to dclk; requests arriving while a
// transfer is in flight are dropped and counted.
module dcmi_hsync
  import dcmi_pkg::*;
#(
  parameter int unsigned DW = DCMI_DW
) (
  input  logic          sclk,
  input  logic          srstn,
  input  logic          dclk,
  input  logic          drstn,
  input  logic          sin,
  input  logic [DW-1:0] sdata,
  output logic          sbusy,
  output logic          sdrop,
  input  logic          sdrop_clr,
  output logic [7:0]    sdrop_cnt,
  output logic          dvld,
  output logic [DW-1:0] ddata
);
  logic          sreq;
  logic          sack_sync;
  logic [DW-1:0] shold;
  logic          dreq_s2;
  logic          dreq_d;
  logic          dack;
  logic          accept;
  logic          reject;
  logic          dnew;

  // ---------------- source domain ----------------
  assign sbusy  = sreq ^ sack_sync;
  assign accept = sin & ~sbusy;
  assign reject = sin & sbusy;

  // shold is a quasi-static CDC path: it is read directly in dclk and only
  // changes while no transfer is in flight.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      sreq  <= 1'b0;
      shold <= '0;
    end else if (accept) begin
      sreq  <= ~sreq;
      shold <= sdata;
    end
  end

  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      sdrop     <= 1'b0;
      sdrop_cnt <= '0;
    end else begin
      sdrop <= reject;
      if (sdrop_clr)
        sdrop_cnt <= {7'd0, reject};
      else if (reject && sdrop_cnt != 8'hFF)
        sdrop_cnt <= sdrop_cnt + 8'd1;
    end
  end

  dcmi_sync2 u_ack_sync (
    .clk  (sclk),
    .rstn (srstn),
    .d    (dack),
    .q    (sack_sync)
  );

  // ---------------- destination domain ----------------
  dcmi_sync2 u_req_sync (
    .clk  (dclk),
    .rstn (drstn),
    .d    (sreq),
    .q    (dreq_s2)
  );

  assign dnew = dreq_s2 ^ dreq_d;
  assign dack = dreq_d;

  always_ff @(posedge dclk or negedge drstn) begin
    if (!drstn) begin
      dreq_d <= 1'b0;
      dvld   <= 1'b0;
      ddata  <= '0;
    end else begin
      dreq_d <= dreq_s2;
      dvld   <= dnew;
      if (dnew)
        ddata <= shold;
    end
  end
endmodule

// File: tb/tb_dcmi_hsync.sv
// Scoreboard bench for dcmi_hsync: accepted words are queued, a dclk monitor
// pops and compares each dvld.
`timescale 1ns/1ps
module tb_dcmi_hsync;
  logic       sclk, srstn, dclk, drstn;
  logic       sin, sdrop_clr;
  logic [7:0] sdata;
  logic       sbusy, sdrop, dvld;
  logic [7:0] sdrop_cnt, ddata;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_exp = 0;
  int   dvld_count = 0;
  int   cnt_m = 0;
  real  dhalf = 13.5;
  int   jit_ps = 0;
  logic [7:0] expq[$];

  dcmi_hsync #(.DW(8)) dut (
    .sclk      (sclk),
    .srstn     (srstn),
    .dclk      (dclk),
    .drstn     (drstn),
    .sin       (sin),
    .sdata     (sdata),
    .sbusy     (sbusy),
    .sdrop     (sdrop),
    .sdrop_clr (sdrop_clr),
    .sdrop_cnt (sdrop_cnt),
    .dvld      (dvld),
    .ddata     (ddata)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    dclk = 1'b0;
    #($urandom_range(0, 9000) / 1000.0);
    forever begin
      #(dhalf + $urandom_range(0, jit_ps) / 1000.0);
      dclk = ~dclk;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every dvld must match the oldest outstanding accepted word.
  always @(negedge dclk) begin
    if (drstn && dvld) begin
      dvld_count++;
      if (expq.size() == 0)
        check("spurious_dvld", int'(dvld), 0);
      else
        check("ddata", int'(ddata), int'(expq.pop_front()));
    end
  end

  // Hold register must not move while a transfer is in flight.
  logic       prev_busy = 1'b0;
  logic [7:0] prev_hold = '0;
  always @(negedge sclk) begin
    if (srstn && prev_busy && sbusy)
      check("hold_stable", int'(dut.shold), int'(prev_hold));
    prev_busy = srstn & sbusy;
    prev_hold = dut.shold;
  end

  task automatic idle();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  // Drives one sclk cycle starting at a negedge; predicts accept/reject.
  task automatic cycle(input logic s, input logic [7:0] d, input logic c);
    logic acc, rej;
    sin = s; sdata = d; sdrop_clr = c;
    acc = s && !sbusy;
    rej = s && sbusy;
    if (acc) begin
      expq.push_back(d);
      n_exp++;
    end
    if (c) cnt_m = rej ? 1 : 0;
    else if (rej && cnt_m < 255) cnt_m++;
    @(posedge sclk);
    @(negedge sclk);
    sin = 1'b0; sdrop_clr = 1'b0;
    check("sdrop", int'(sdrop), int'(rej));
    check("sdrop_cnt", int'(sdrop_cnt), cnt_m);
    if (acc) check("sbusy_after_accept", int'(sbusy), 1);
  endtask

  task automatic send_word(input logic [7:0] d);
    int n = 0;
    while (sbusy && n < 400) begin
      idle();
      n++;
    end
    if (sbusy) check("busy_timeout", int'(sbusy), 0);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || sbusy) && n < 400) begin
      idle();
      n++;
    end
    check("drain_queue", expq.size(), 0);
    check("drain_sbusy", int'(sbusy), 0);
  endtask

  initial begin
    int rej_n;
    int iter;
    logic [7:0] w;
    sin = 1'b0; sdata = '0; sdrop_clr = 1'b0;
    srstn = 1'b0; drstn = 1'b0;
    repeat (4) @(negedge sclk);
    check("rst_sbusy", int'(sbusy), 0);
    check("rst_sdrop", int'(sdrop), 0);
    check("rst_sdrop_cnt", int'(sdrop_cnt), 0);
    check("rst_dvld", int'(dvld), 0);
    check("rst_ddata", int'(ddata), 0);
    srstn = 1'b1;
    @(negedge dclk); drstn = 1'b1;
    @(negedge sclk);
    idle();

    // Basic transfer, dclk 37 MHz
    dhalf = 13.5;
    cycle(1'b1, 8'hA5, 1'b0);
    drain();
    check("basic_dvld_count", dvld_count, n_exp);
    check("basic_sdrop_cnt", int'(sdrop_cnt), 0);

    // Reject one cycle after accept
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("reject_sdrop_cnt", int'(sdrop_cnt), 1);
    drain();
    check("reject_dvld_count", dvld_count, n_exp);
    cycle(1'b0, 8'h00, 1'b1);

    // Throughput with fast then slow dclk, randomized jitter
    jit_ps = 300;
    dhalf = 2.0;
    for (int i = 0; i < 100; i++) send_word(8'(i));
    drain();
    dhalf = 25.0;
    for (int i = 0; i < 100; i++) send_word(8'(i));
    drain();
    check("thru_dvld_count", dvld_count, n_exp);
    check("thru_sdrop_cnt", int'(sdrop_cnt), 0);

    // Reset mid-transfer, slow dclk so nothing is delivered before reset
    cycle(1'b1, 8'h77, 1'b0);
    srstn = 1'b0; drstn = 1'b0;
    expq.delete();
    n_exp--;
    cnt_m = 0;
    repeat (5) @(negedge sclk);
    check("midrst_sbusy", int'(sbusy), 0);
    check("midrst_sdrop", int'(sdrop), 0);
    check("midrst_sdrop_cnt", int'(sdrop_cnt), 0);
    check("midrst_dvld", int'(dvld), 0);
    check("midrst_ddata", int'(ddata), 0);
    srstn = 1'b1;
    @(negedge dclk); drstn = 1'b1;
    @(negedge sclk);
    repeat (3) idle();
    send_word(8'h5A);
    drain();
    check("post_rst_dvld_count", dvld_count, n_exp);
    check("post_rst_ddata", int'(ddata), 8'h5A);

    // Saturation: 300 rejects, then clear together with a reject
    rej_n = 0; iter = 0; w = 8'h80;
    while (rej_n < 300 && iter < 20000) begin
      if (sbusy) begin
        cycle(1'b1, 8'hEE, 1'b0);
        rej_n++;
      end else begin
        cycle(1'b1, w, 1'b0);
        w++;
      end
      iter++;
    end
    check("sat_rejects", rej_n, 300);
    check("sat_sdrop_cnt", int'(sdrop_cnt), 255);
    if (!sbusy) cycle(1'b1, w, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    check("clr_with_reject", int'(sdrop_cnt), 1);
    drain();
    check("final_dvld_count", dvld_count, n_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
